// File: rtl/canvas_pkg.sv
// Shared opcodes, FSM states and argument targets for the canvas pixel engine.
package canvas_pkg;

  localparam logic [3:0] OP_SET_X     = 4'h1;
  localparam logic [3:0] OP_SET_Y     = 4'h2;
  localparam logic [3:0] OP_SET_COLOR = 4'h3;
  localparam logic [3:0] OP_PLOT      = 4'h4;
  localparam logic [3:0] OP_CLEAR     = 4'h5;
  localparam logic [3:0] OP_READ      = 4'h6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARG  = 2'd1,
    CLR  = 2'd2,
    RD   = 2'd3
  } state_e;

  typedef enum logic {
    TGT_X = 1'b0,
    TGT_Y = 1'b1
  } tgt_e;

endpackage

// File: rtl/canvas_fb.sv
// Flop-based framebuffer: one synchronous write port, two combinational read ports.
module canvas_fb
  import canvas_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int BPP    = 2,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we_i,
  input  logic [XW-1:0]  wx_i,
  input  logic [YW-1:0]  wy_i,
  input  logic [BPP-1:0] wdata_i,
  input  logic [XW-1:0]  rx_i,
  input  logic [YW-1:0]  ry_i,
  output logic [BPP-1:0] rdata_o,
  input  logic [XW-1:0]  sx_i,
  input  logic [YW-1:0]  sy_i,
  output logic [BPP-1:0] sdata_o
);

  logic [BPP-1:0] mem_q [HEIGHT][WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int yy = 0; yy < HEIGHT; yy++) begin
        for (int xx = 0; xx < WIDTH; xx++) begin
          mem_q[yy][xx] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wy_i][wx_i] <= wdata_i;
    end
  end

  // Engine port only ever addresses the cursor, which is always in range.
  assign rdata_o = mem_q[ry_i][rx_i];

  // The scan port is driven externally, so coordinates beyond the canvas read as 0.
  always_comb begin
    sdata_o = '0;
    if (({1'b0, sx_i} < (XW+1)'(WIDTH)) && ({1'b0, sy_i} < (YW+1)'(HEIGHT))) begin
      sdata_o = mem_q[sy_i][sx_i];
    end
  end

endmodule

// File: rtl/canvas_pixel_engine.sv
// Byte-command drawing core: cursor/colour state, plot, clear, readback and a scan port.
module canvas_pixel_engine
  import canvas_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  HEIGHT = 16,
  parameter int  BPP    = 2,
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [7:0]     cmd_data,
  output logic           rd_valid,
  output logic [BPP-1:0] rd_data,
  output logic           busy,
  output logic           bad_cmd,
  output logic [XW-1:0]  cur_x,
  output logic [YW-1:0]  cur_y,
  input  logic [XW-1:0]  scan_x,
  input  logic [YW-1:0]  scan_y,
  output logic [BPP-1:0] scan_data
);

  state_e         state_q, state_d;
  tgt_e           tgt_q, tgt_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [BPP-1:0] color_q, color_d;
  logic [XW-1:0]  clr_x_q, clr_x_d;
  logic [YW-1:0]  clr_y_q, clr_y_d;
  logic [BPP-1:0] rd_data_q, rd_data_d;
  logic           bad_q, bad_d;

  logic           fb_we;
  logic [XW-1:0]  fb_wx;
  logic [YW-1:0]  fb_wy;
  logic [BPP-1:0] fb_wdata;
  logic [BPP-1:0] fb_rdata;
  logic [3:0]     opcode;
  logic [8:0]     arg9;

  assign opcode = cmd_data[7:4];
  assign arg9   = {1'b0, cmd_data};

  canvas_fb #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .BPP   (BPP),
    .XW    (XW),
    .YW    (YW)
  ) u_fb (
    .clk    (clk),
    .rst    (rst),
    .we_i   (fb_we),
    .wx_i   (fb_wx),
    .wy_i   (fb_wy),
    .wdata_i(fb_wdata),
    .rx_i   (x_q),
    .ry_i   (y_q),
    .rdata_o(fb_rdata),
    .sx_i   (scan_x),
    .sy_i   (scan_y),
    .sdata_o(scan_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= TGT_X;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
      clr_x_q   <= '0;
      clr_y_q   <= '0;
      rd_data_q <= '0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      color_q   <= color_d;
      clr_x_q   <= clr_x_d;
      clr_y_q   <= clr_y_d;
      rd_data_q <= rd_data_d;
      bad_q     <= bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    x_d       = x_q;
    y_d       = y_q;
    color_d   = color_q;
    clr_x_d   = clr_x_q;
    clr_y_d   = clr_y_q;
    rd_data_d = rd_data_q;
    bad_d     = bad_q;
    fb_we     = 1'b0;
    fb_wx     = x_q;
    fb_wy     = y_q;
    fb_wdata  = color_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (opcode)
            OP_SET_X: begin
              tgt_d   = TGT_X;
              state_d = ARG;
            end
            OP_SET_Y: begin
              tgt_d   = TGT_Y;
              state_d = ARG;
            end
            OP_SET_COLOR: color_d = cmd_data[BPP-1:0];
            OP_PLOT: begin
              fb_we = 1'b1;
              // Raster advance with full wrap back to the origin.
              if (x_q == XW'(WIDTH-1)) begin
                x_d = '0;
                if (y_q == YW'(HEIGHT-1)) begin
                  y_d = '0;
                end else begin
                  y_d = y_q + 1'b1;
                end
              end else begin
                x_d = x_q + 1'b1;
              end
            end
            OP_CLEAR: begin
              clr_x_d = '0;
              clr_y_d = '0;
              state_d = CLR;
            end
            OP_READ: begin
              rd_data_d = fb_rdata;
              state_d   = RD;
            end
            default: bad_d = 1'b1;
          endcase
        end
      end

      ARG: begin
        if (cmd_valid) begin
          state_d = IDLE;
          if (tgt_q == TGT_X) begin
            if (arg9 >= 9'(WIDTH)) begin
              x_d   = XW'(WIDTH-1);
              bad_d = 1'b1;
            end else begin
              x_d = XW'(cmd_data);
            end
          end else begin
            if (arg9 >= 9'(HEIGHT)) begin
              y_d   = YW'(HEIGHT-1);
              bad_d = 1'b1;
            end else begin
              y_d = YW'(cmd_data);
            end
          end
        end
      end

      CLR: begin
        fb_we = 1'b1;
        fb_wx = clr_x_q;
        fb_wy = clr_y_q;
        if (clr_x_q == XW'(WIDTH-1)) begin
          clr_x_d = '0;
          if (clr_y_q == YW'(HEIGHT-1)) begin
            clr_y_d = '0;
            x_d     = '0;
            y_d     = '0;
            state_d = IDLE;
          end else begin
            clr_y_d = clr_y_q + 1'b1;
          end
        end else begin
          clr_x_d = clr_x_q + 1'b1;
        end
      end

      RD: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE) || (state_q == ARG);
  assign busy      = (state_q == CLR);
  assign rd_valid  = (state_q == RD);
  assign rd_data   = rd_data_q;
  assign bad_cmd   = bad_q;
  assign cur_x     = x_q;
  assign cur_y     = y_q;

endmodule

// File: tb/tb_canvas_pixel_engine.sv
// Directed, table-driven bench for canvas_pixel_engine at the default 16x16x2 geometry.
module tb_canvas_pixel_engine;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rd_valid;
  logic [1:0] rd_data;
  logic       busy;
  logic       bad_cmd;
  logic [3:0] cur_x;
  logic [3:0] cur_y;
  logic [3:0] scan_x;
  logic [3:0] scan_y;
  logic [1:0] scan_data;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] sx;
    logic [3:0] sy;
    logic [3:0] ex;
    logic [3:0] ey;
    logic       eBad;
    logic [1:0] eScan;
  } vec_t;

  vec_t vecs[$];

  canvas_pixel_engine dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .bad_cmd  (bad_cmd),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .scan_x   (scan_x),
    .scan_y   (scan_y),
    .scan_data(scan_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one byte for exactly one rising edge; returns 1 ns after that edge.
  task automatic applyStimulus(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic sweepScan(input string name, input int expected);
    int nBad = 0;
    for (int yy = 0; yy < 16; yy++) begin
      for (int xx = 0; xx < 16; xx++) begin
        scan_x = 4'(xx);
        scan_y = 4'(yy);
        #1;
        if (32'(scan_data) != 32'(expected)) nBad++;
      end
    end
    checkOutput(name, 32'(nBad), 0);
  endtask

  initial begin
    int n;

    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    scan_x    = '0;
    scan_y    = '0;
    rst       = 1'b1;

    vecs.push_back('{8'h15, 4'd5,  4'd3,  4'd0,  4'd0,  1'b0, 2'd0});
    vecs.push_back('{8'h05, 4'd5,  4'd3,  4'd5,  4'd0,  1'b0, 2'd0});
    vecs.push_back('{8'h20, 4'd5,  4'd3,  4'd5,  4'd0,  1'b0, 2'd0});
    vecs.push_back('{8'h03, 4'd5,  4'd3,  4'd5,  4'd3,  1'b0, 2'd0});
    vecs.push_back('{8'h32, 4'd5,  4'd3,  4'd5,  4'd3,  1'b0, 2'd0});
    vecs.push_back('{8'h40, 4'd5,  4'd3,  4'd6,  4'd3,  1'b0, 2'd2});
    vecs.push_back('{8'h40, 4'd6,  4'd3,  4'd7,  4'd3,  1'b0, 2'd2});
    vecs.push_back('{8'h10, 4'd15, 4'd15, 4'd7,  4'd3,  1'b0, 2'd0});
    vecs.push_back('{8'h0F, 4'd15, 4'd15, 4'd15, 4'd3,  1'b0, 2'd0});
    vecs.push_back('{8'h2A, 4'd15, 4'd15, 4'd15, 4'd3,  1'b0, 2'd0});
    vecs.push_back('{8'h0F, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 2'd0});
    vecs.push_back('{8'h40, 4'd15, 4'd15, 4'd0,  4'd0,  1'b0, 2'd2});
    vecs.push_back('{8'h10, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 2'd0});
    vecs.push_back('{8'h20, 4'd0,  4'd0,  4'd15, 4'd0,  1'b1, 2'd0});
    vecs.push_back('{8'h20, 4'd15, 4'd0,  4'd15, 4'd0,  1'b1, 2'd0});
    vecs.push_back('{8'h40, 4'd15, 4'd0,  4'd15, 4'd15, 1'b1, 2'd0});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady",  32'(cmd_ready), 1);
    checkOutput("rstBusy",   32'(busy), 0);
    checkOutput("rstRdValid", 32'(rd_valid), 0);
    checkOutput("rstRdData", 32'(rd_data), 0);
    checkOutput("rstBad",    32'(bad_cmd), 0);
    checkOutput("rstCurX",   32'(cur_x), 0);
    checkOutput("rstCurY",   32'(cur_y), 0);
    sweepScan("rstPixelsNonZero", 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table: cursor, clamp, plot, wrap and argument-not-decoded behaviour.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cmd);
      scan_x = vecs[i].sx;
      scan_y = vecs[i].sy;
      #1;
      checkOutput($sformatf("vec%0d.curX", i),  32'(cur_x), 32'(vecs[i].ex));
      checkOutput($sformatf("vec%0d.curY", i),  32'(cur_y), 32'(vecs[i].ey));
      checkOutput($sformatf("vec%0d.bad", i),   32'(bad_cmd), 32'(vecs[i].eBad));
      checkOutput($sformatf("vec%0d.scan", i),  32'(scan_data), 32'(vecs[i].eScan));
      checkOutput($sformatf("vec%0d.ready", i), 32'(cmd_ready), 1);
    end

    // CLEAR with cmd_valid held high: busy for exactly WIDTH*HEIGHT cycles.
    applyStimulus(8'h31);
    cmd_valid = 1'b1;
    cmd_data  = 8'h50;
    @(posedge clk);
    #1;
    n = 0;
    while (busy && n < 1000) begin
      checkOutput("clrReadyLow", 32'(cmd_ready), 0);
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    checkOutput("clrBusyCycles", 32'(n), 256);
    checkOutput("clrReadyAfter", 32'(cmd_ready), 1);
    checkOutput("clrCurX", 32'(cur_x), 0);
    checkOutput("clrCurY", 32'(cur_y), 0);
    sweepScan("clrPixelsNotOne", 1);

    // Scan shows old value during the write cycle, then the new one.
    applyStimulus(8'h33);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h20);
    applyStimulus(8'h07);
    scan_x    = 4'd2;
    scan_y    = 4'd7;
    cmd_valid = 1'b1;
    cmd_data  = 8'h40;
    #1;
    checkOutput("scanOldInWrite", 32'(scan_data), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("scanNewAfterEdge", 32'(scan_data), 3);
    checkOutput("plotCurX", 32'(cur_x), 3);
    checkOutput("plotCurY", 32'(cur_y), 7);

    // READ back (2,7): one-cycle latency, cursor unchanged.
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h20);
    applyStimulus(8'h07);
    checkOutput("rdValidBefore", 32'(rd_valid), 0);
    applyStimulus(8'h60);
    checkOutput("rdValidPulse", 32'(rd_valid), 1);
    checkOutput("rdData", 32'(rd_data), 3);
    checkOutput("rdReadyLow", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("rdValidDrop", 32'(rd_valid), 0);
    checkOutput("rdReadyBack", 32'(cmd_ready), 1);
    checkOutput("rdCurX", 32'(cur_x), 2);
    checkOutput("rdCurY", 32'(cur_y), 7);

    // Reset during CLEAR aborts to the reset state.
    applyStimulus(8'h50);
    repeat (99) @(posedge clk);
    #1;
    checkOutput("midClrBusy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("abortBusy",  32'(busy), 0);
    checkOutput("abortReady", 32'(cmd_ready), 1);
    checkOutput("abortRdData", 32'(rd_data), 0);
    checkOutput("abortBad",   32'(bad_cmd), 0);
    checkOutput("abortCurX",  32'(cur_x), 0);
    checkOutput("abortCurY",  32'(cur_y), 0);
    sweepScan("abortPixelsNonZero", 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset during ARG discards the pending argument; colour is back to 0.
    applyStimulus(8'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(8'h45);
    scan_x = 4'd0;
    scan_y = 4'd0;
    #1;
    checkOutput("argAbortCurX", 32'(cur_x), 1);
    checkOutput("argAbortCurY", 32'(cur_y), 0);
    checkOutput("argAbortBad",  32'(bad_cmd), 0);
    checkOutput("argAbortPixel", 32'(scan_data), 0);

    // Illegal opcode sets the sticky flag without touching pixels.
    applyStimulus(8'h90);
    checkOutput("illegalBad", 32'(bad_cmd), 1);
    checkOutput("illegalCurX", 32'(cur_x), 1);
    sweepScan("illegalPixelsChanged", 0);
    applyStimulus(8'h31);
    checkOutput("badSticky", 32'(bad_cmd), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
